// File: rtl/fft_frame_collector.sv
// -----------------------------------------------------------------------------
// fft_frame_collector
//
// Collects a stream of time-domain samples into fixed-size frames for a
// downstream FFT. Two banks ping-pong: while one bank is waiting to be
// consumed, the other one fills. A bank is never written while it is full, so
// a stalled consumer back-pressures the sample stream through in_ready instead
// of losing samples.
//
// Parameters
//   WIDTH   : bits per sample (>= 1)
//   SAMPLES : samples per frame (power of 2, >= 2)
//
// Ports
//   clk         : rising-edge clock for all state
//   rst         : asynchronous, active-low reset
//   in_valid    : in_sample holds a valid sample
//   in_sample   : streaming sample, WIDTH bits
//   in_ready    : a sample can be accepted this cycle
//   flush       : synchronous discard of the partially filled frame
//   frame_valid : frame_out holds a complete frame
//   frame_ready : downstream consumes the frame this cycle
//   frame_out   : SAMPLES entries; entry i is the i-th sample of the frame
//   frame_count : frames consumed, wraps modulo 2^16
// -----------------------------------------------------------------------------
module fft_frame_collector #(
  parameter int WIDTH   = 16,
  parameter int SAMPLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sample,
  output logic             in_ready,
  input  logic             flush,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] frame_out [SAMPLES],
  output logic [15:0]      frame_count
);

  localparam int                IDX_W    = $clog2(SAMPLES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SAMPLES - 1);

  logic [WIDTH-1:0] r_bank [2][SAMPLES];
  logic [1:0]       r_full;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic [15:0]      r_frame_count;

  logic             w_accept;
  logic             w_write;
  logic             w_complete;
  logic             w_consume;
  logic [1:0]       w_set_full;
  logic [1:0]       w_clr_full;

  // Ready depends only on the fill bank's state, never on in_valid, so the
  // upstream handshake has no combinational loop through this block.
  assign in_ready    = ~r_full[r_wr_bank];
  assign frame_valid = r_full[r_rd_bank];
  assign frame_count = r_frame_count;

  assign w_accept   = in_valid & in_ready;
  // A flush discards the sample handshaked in the same cycle.
  assign w_write    = w_accept & ~flush;
  // Flush wins over completion: a flushed frame is never marked full.
  assign w_complete = w_write & (r_wr_idx == LAST_IDX);
  assign w_consume  = frame_valid & frame_ready;

  // Completion targets the fill bank (which was not full), consumption targets
  // the read bank (which was full), so the two can never hit the same bank.
  assign w_set_full = {w_complete &  r_wr_bank, w_complete & ~r_wr_bank};
  assign w_clr_full = {w_consume  &  r_rd_bank, w_consume  & ~r_rd_bank};

  // NOTE: always_comb drives every element on every pass, so no latch is
  // inferred for frame_out.
  always_comb begin
    for (int i = 0; i < SAMPLES; i++) begin
      frame_out[i] = r_bank[r_rd_bank][i];
    end
  end

  // NOTE: the sample banks are reset too, because frame_out must read all
  // zeros while reset is held and stale data must not survive a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SAMPLES; i++) begin
          r_bank[b][i] <= '0;
        end
      end
    end else if (w_write) begin
      r_bank[r_wr_bank][r_wr_idx] <= in_sample;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full        <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_idx      <= '0;
      r_frame_count <= '0;
    end else begin
      r_full <= (r_full | w_set_full) & ~w_clr_full;

      if (flush) begin
        r_wr_idx <= '0;
      end else if (w_write) begin
        // SAMPLES is a power of 2, so the increment wraps to 0 on its own.
        r_wr_idx <= r_wr_idx + 1'b1;
      end

      if (w_complete) begin
        r_wr_bank <= ~r_wr_bank;
      end

      if (w_consume) begin
        r_rd_bank     <= ~r_rd_bank;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_collector
//
// Directed bench for fft_frame_collector (WIDTH=16, SAMPLES=8). Inputs change
// and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_fft_frame_collector;

  localparam int WIDTH   = 16;
  localparam int SAMPLES = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_sample;
  logic             in_ready;
  logic             flush;
  logic             frame_valid;
  logic             frame_ready;
  logic [WIDTH-1:0] frame_out [SAMPLES];
  logic [15:0]      frame_count;

  int n_checks = 0;
  int n_fails  = 0;

  fft_frame_collector #(
    .WIDTH   (WIDTH),
    .SAMPLES (SAMPLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sample   (in_sample),
    .in_ready    (in_ready),
    .flush       (flush),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_out   (frame_out),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one edge.
  task automatic push(input int v, input logic fl = 1'b0, input logic fr = 1'b0);
    in_valid    = 1'b1;
    in_sample   = WIDTH'(v);
    flush       = fl;
    frame_ready = fr;
    tick();
    in_valid    = 1'b0;
    flush       = 1'b0;
    frame_ready = 1'b0;
  endtask

  task automatic push_run(input int first, input int n);
    for (int k = 0; k < n; k++) push(first + k);
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  // Expected frame: entries base, base+1, ... in acceptance order.
  task automatic check_frame(input string tag, input int base);
    for (int i = 0; i < SAMPLES; i++) begin
      check($sformatf("%s[%0d]", tag, i), 32'(frame_out[i]), 32'(base + i));
    end
  endtask

  task automatic check_zero_frame(input string tag);
    logic [WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < SAMPLES; i++) acc |= frame_out[i];
    check(tag, 32'(acc), 32'd0);
  endtask

  initial begin
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_sample   = '0;
    flush       = 1'b0;
    frame_ready = 1'b0;

    // ---- reset state ----
    tick(); tick();
    check("rst_in_ready",    32'(in_ready),    32'd1);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check_zero_frame("rst_frame_out");
    rst = 1'b1;

    // ---- single frame 1..8, first accepted at the first edge after release ----
    for (int k = 1; k <= SAMPLES; k++) begin
      check($sformatf("single_in_ready_%0d", k), 32'(in_ready), 32'd1);
      if (k == SAMPLES) check("single_valid_before_last", 32'(frame_valid), 32'd0);
      push(k);
    end
    check("single_frame_valid", 32'(frame_valid), 32'd1);
    check("single_in_ready",    32'(in_ready),    32'd1);
    check_frame("single", 1);

    // ---- backpressure: 9..16 fill B1, 17 is then stalled ----
    push_run(9, 8);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_valid  = 1'b1;
    in_sample = 16'd17;
    repeat (3) tick();
    check("bp_hold_valid", 32'(frame_valid), 32'd1);
    check_frame("bp_hold", 1);
    check("bp_count_0", 32'(frame_count), 32'd0);
    frame_ready = 1'b1;  // 17 still presented, not accepted at this edge
    tick();
    frame_ready = 1'b0;
    in_valid    = 1'b0;
    check("bp_count_1",      32'(frame_count), 32'd1);
    check("bp_in_ready_back",32'(in_ready),    32'd1);
    check("bp_valid_next",   32'(frame_valid), 32'd1);
    check_frame("bp_next", 9);
    push_run(17, 8);     // fills B0 again
    check("bp_full_again", 32'(in_ready), 32'd0);
    consume();           // consume 9..16
    check("bp_count_2", 32'(frame_count), 32'd2);
    check_frame("bp_third", 17);

    // ---- simultaneity: B0 full, B1 completes while B0 is consumed ----
    push_run(101, 7);
    check("sim_count_pre", 32'(frame_count), 32'd2);
    push(108, 1'b0, 1'b1);
    check("sim_count",       32'(frame_count), 32'd3);
    check("sim_frame_valid", 32'(frame_valid), 32'd1);
    check("sim_in_ready",    32'(in_ready),    32'd1);
    check_frame("sim_b1", 101);
    consume();
    check("sim_count_4",  32'(frame_count), 32'd4);
    check("sim_drained",  32'(frame_valid), 32'd0);

    // ---- flush mid-frame: handshaked sample on the flush edge is dropped ----
    push_run(201, 5);
    push(206, 1'b1);
    push_run(301, 8);
    check("flush_frame_valid", 32'(frame_valid), 32'd1);
    check_frame("flush_new", 301);
    consume();
    check("flush_count", 32'(frame_count), 32'd5);

    // ---- flush on the 8th sample: no frame ----
    push_run(401, 7);
    push(408, 1'b1);
    check("flush8_no_valid", 32'(frame_valid), 32'd0);
    check("flush8_in_ready", 32'(in_ready),    32'd1);
    push_run(501, 8);
    check("flush8_refill_valid", 32'(frame_valid), 32'd1);
    check_frame("flush8_refill", 501);

    // ---- reset mid-operation: one bank full, other at wr_idx=3 ----
    push_run(601, 3);
    rst = 1'b0;
    #1;
    check("midrst_frame_valid", 32'(frame_valid), 32'd0);
    check("midrst_in_ready",    32'(in_ready),    32'd1);
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    check_zero_frame("midrst_frame_out");
    tick();
    rst = 1'b1;
    push_run(701, 7);
    check("postrst_partial", 32'(frame_valid), 32'd0);
    push(708);
    check("postrst_valid", 32'(frame_valid), 32'd1);
    check_frame("postrst", 701);

    // ---- frame_count wrap: preload near the top, then consume twice ----
    force dut.r_frame_count = 16'hFFFE;
    #1;
    release dut.r_frame_count;
    #1;
    check("wrap_preload", 32'(frame_count), 32'h0000_FFFE);
    consume();
    check("wrap_ffff", 32'(frame_count), 32'h0000_FFFF);
    push_run(801, 8);
    consume();
    check("wrap_zero", 32'(frame_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fft_frame_collector.md
FFT_FRAME_COLLECTOR -- requirements
Module: fft_frame_collector

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and rst.
REQ-002 Parameter WIDTH SHALL default to 16 and set the bits per sample; legal values are 1 or more.
REQ-003 Parameter SAMPLES SHALL default to 8 and set the samples per FFT frame; legal values are powers of 2, minimum 2.
REQ-004 clk SHALL be an input, 1 bit: rising-edge clock for all state.
REQ-005 rst SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 in_valid SHALL be an input, 1 bit: in_sample holds a valid sample.
REQ-007 in_sample SHALL be an input, WIDTH bits: streaming time-domain sample.
REQ-008 in_ready SHALL be an output, 1 bit: the block can accept a sample this cycle.
REQ-009 flush SHALL be an input, 1 bit: synchronous discard of the partially filled frame.
REQ-010 frame_valid SHALL be an output, 1 bit: frame_out holds a complete frame.
REQ-011 frame_ready SHALL be an input, 1 bit: the downstream FFT consumes the frame.
REQ-012 frame_out SHALL be an output, an unpacked array of SAMPLES entries, each WIDTH bits: entry i is the i-th sample accepted into the frame.
REQ-013 frame_count SHALL be an output, 16 bits: number of frames consumed, wrapping modulo 2^16.

Function
REQ-014 Storage SHALL be two banks (B0, B1) of SAMPLES x WIDTH, plus a full flag per bank, wr_bank, wr_idx ($clog2(SAMPLES) bits) and rd_bank.
REQ-015 in_ready SHALL equal NOT full[wr_bank], combinationally, with no dependence on in_valid.
REQ-016 A sample SHALL be accepted when in_valid && in_ready at a clk edge; it is written to bank[wr_bank][wr_idx] and wr_idx increments.
REQ-017 On acceptance with wr_idx == SAMPLES-1: full[wr_bank] sets, wr_bank toggles and wr_idx wraps to 0.
REQ-018 frame_valid SHALL equal full[rd_bank], and frame_out SHALL equal bank[rd_bank].
REQ-019 Latency: when the last sample of a frame is accepted at edge N, frame_valid SHALL be high after edge N (one cycle), if rd_bank points at that bank.
REQ-020 A frame SHALL be consumed when frame_valid && frame_ready: full[rd_bank] clears, rd_bank toggles and frame_count increments.
REQ-021 While frame_valid=1 and frame_ready=0, frame_out and frame_valid SHALL hold stable.
REQ-022 A bank SHALL never be written while its full flag is set; samples are never overwritten or dropped.
REQ-023 Simultaneous frame completion on one bank and consumption of the other in the same cycle SHALL both take effect.
REQ-024 Simultaneous completion and consumption cannot target the same bank; if both banks are full, in_ready=0.
REQ-025 flush=1 at an edge SHALL set wr_idx to 0 and discard that cycle's sample even if handshaked; full flags, rd_bank and frame_count are unaffected.
REQ-026 flush has priority over the REQ-017 completion in the same cycle: the frame SHALL NOT be marked full.
REQ-027 Consumption SHALL proceed normally during flush.
REQ-028 Frames SHALL be delivered in the order completed; steady state allows one sample per cycle with back-to-back frames when frame_ready=1.
REQ-029 frame_count SHALL wrap from 16'hFFFF to 0.

Reset
REQ-030 While rst=0: banks zeroed, full flags 0, wr_bank=0, rd_bank=0, wr_idx=0, frame_count=0.
REQ-031 While rst=0, outputs SHALL be in_ready=1, frame_valid=0 and frame_out all zeros.
REQ-032 Assertion of rst mid-frame or mid-handshake SHALL discard all data immediately.
REQ-033 The first acceptance SHALL be allowed at the first clk edge after rst deasserts.

Verification (WIDTH=16, SAMPLES=8)
REQ-034 Single frame: stream 1..8 with in_valid=1 and frame_ready=0 -> frame_valid=1 one cycle after the 8th sample, frame_out={1..8} in order, in_ready stays 1.
REQ-035 Backpressure: stream 24 samples with frame_ready=0 -> in_ready=0 after sample 16, frames {1..8} held stable; assert frame_ready for one cycle -> frame_count=1, next frame {9..16}, in_ready returns to 1.
REQ-036 Simultaneity: B0 full, B1 on its 8th sample, frame_ready=1 in the same cycle -> both banks' flags update, frame_valid stays 1 showing B1 data, frame_count increments.
REQ-037 Flush: accept 5 samples, flush=1 with in_valid=1, then stream 8 new samples -> the frame contains only the 8 new samples; flush on the 8th sample -> no frame_valid.
REQ-038 Reset mid-operation: rst=0 with one bank full and wr_idx=3 -> frame_valid=0, in_ready=1, frame_count=0, frame_out all zeros; normal operation after release.
REQ-039 Wrap: force 65536 consumptions -> frame_count returns to 0.
